// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: step/phase timing controller for the two-street light FSM.
// Keeps a shadow phase, an actuated main-green age and a per-phase dwell counter.
`default_nettype none
`timescale 1ns/1ps

module traffic_phase_scheduler #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 8,
  parameter int MG_MIN   = 20,
  parameter int MG_MAX   = 60,
  parameter int Y_T      = 4,
  parameter int AR_T     = 2,
  parameter int SG_T     = 10,
  parameter int PED_T    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sideCar,
  input  logic             pedOn,
  input  logic             hold,
  output logic             step,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwellLeft,
  output logic             cycleDone
);

  localparam int PS_W = $clog2(TICK_DIV);

  localparam logic [2:0] PH_GR  = 3'd0;
  localparam logic [2:0] PH_YR  = 3'd1;
  localparam logic [2:0] PH_RR1 = 3'd2;
  localparam logic [2:0] PH_RG  = 3'd3;
  localparam logic [2:0] PH_RY  = 3'd4;
  localparam logic [2:0] PH_RR2 = 3'd5;
  localparam logic [2:0] PH_PED = 3'd6;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MG_MIN_C = CNT_W'(MG_MIN);
  localparam logic [CNT_W-1:0] MG_MAX_C = CNT_W'(MG_MAX);
  localparam logic [CNT_W-1:0] Y_C      = CNT_W'(Y_T);
  localparam logic [CNT_W-1:0] AR_C     = CNT_W'(AR_T);
  localparam logic [CNT_W-1:0] SG_C     = CNT_W'(SG_T);
  localparam logic [CNT_W-1:0] PED_C    = CNT_W'(PED_T);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // Parameter sanity: elaboration stops on any out-of-range setting.
  if (TICK_DIV < 2) begin : g_chk_tick
    $fatal(1, "traffic_phase_scheduler: TICK_DIV must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_chk_width
    $fatal(1, "traffic_phase_scheduler: CNT_W out of range");
  end
  if (MG_MIN < 1 || MG_MAX <= MG_MIN || MG_MAX >= (1 << CNT_W)) begin : g_chk_green
    $fatal(1, "traffic_phase_scheduler: need 1 <= MG_MIN < MG_MAX < 2**CNT_W");
  end
  if (Y_T < 1 || AR_T < 1 || SG_T < 1 || PED_T < 1) begin : g_chk_dur_lo
    $fatal(1, "traffic_phase_scheduler: phase durations must be >= 1");
  end
  if (Y_T >= (1 << CNT_W) || AR_T >= (1 << CNT_W) ||
      SG_T >= (1 << CNT_W) || PED_T >= (1 << CNT_W)) begin : g_chk_dur_hi
    $fatal(1, "traffic_phase_scheduler: phase duration does not fit CNT_W");
  end

  function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] ph);
    logic [CNT_W-1:0] d;
    d = '0;
    case (ph)
      PH_YR, PH_RY:   d = Y_C;
      PH_RR1, PH_RR2: d = AR_C;
      PH_RG:          d = SG_C;
      PH_PED:         d = PED_C;
      default:        d = '0;
    endcase
    return d;
  endfunction

  logic [2:0]       phase_q, phase_d;
  logic             step_q, step_d;
  logic             cycle_done_q, cycle_done_d;
  logic [PS_W-1:0]  prescaler_q, prescaler_d;
  logic [CNT_W-1:0] green_age_q, green_age_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  logic             tick;
  logic             phase_legal;
  logic             end_cond;
  logic [2:0]       next_phase;
  logic [CNT_W-1:0] green_age_inc;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= PH_GR;
      step_q       <= 1'b0;
      cycle_done_q <= 1'b0;
      prescaler_q  <= '0;
      green_age_q  <= '0;
      dwell_q      <= '0;
    end else begin
      phase_q      <= phase_d;
      step_q       <= step_d;
      cycle_done_q <= cycle_done_d;
      prescaler_q  <= prescaler_d;
      green_age_q  <= green_age_d;
      dwell_q      <= dwell_d;
    end
  end

  // Next-state logic
  always_comb begin
    tick          = (prescaler_q == PS_LAST);
    phase_legal   = (phase_q <= PH_PED);
    green_age_inc = (green_age_q >= MG_MAX_C) ? MG_MAX_C : green_age_q + ONE_C;

    end_cond = 1'b0;
    if (!phase_legal) begin
      end_cond = 1'b1;
    end else if (!hold && tick) begin
      if (phase_q == PH_GR) begin
        // Post-increment age decides, so the cap and the minimum land on their own tick.
        end_cond = ((green_age_inc >= MG_MIN_C) && (sideCar || pedOn)) ||
                   (green_age_inc == MG_MAX_C);
      end else begin
        end_cond = (dwell_q <= ONE_C);
      end
    end

    case (phase_q)
      PH_GR:   next_phase = PH_YR;
      PH_YR:   next_phase = PH_RR1;
      PH_RR1:  next_phase = PH_RG;
      PH_RG:   next_phase = PH_RY;
      PH_RY:   next_phase = PH_RR2;
      PH_RR2:  next_phase = pedOn ? PH_PED : PH_GR;
      default: next_phase = PH_GR;
    endcase

    phase_d      = phase_q;
    step_d       = 1'b0;
    cycle_done_d = 1'b0;
    prescaler_d  = prescaler_q;
    green_age_d  = green_age_q;
    dwell_d      = dwell_q;

    if (!hold) begin
      prescaler_d = tick ? '0 : prescaler_q + 1'b1;
      if (tick) begin
        if (phase_q == PH_GR) green_age_d = green_age_inc;
        else if (dwell_q != '0) dwell_d = dwell_q - ONE_C;
      end
    end

    if (end_cond) begin
      phase_d      = next_phase;
      step_d       = 1'b1;
      cycle_done_d = (next_phase == PH_GR);
      dwell_d      = dur_of(next_phase);
      green_age_d  = '0;
      prescaler_d  = '0;
    end
  end

  // Outputs
  always_comb begin
    phase     = phase_q;
    step      = step_q;
    cycleDone = cycle_done_q;
    dwellLeft = (phase_q == PH_GR) ? (MG_MAX_C - green_age_q) : dwell_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed self-checking bench for traffic_phase_scheduler.
`default_nettype none
`timescale 1ns/1ps

module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sideCar = 1'b0;
  logic       pedOn = 1'b0;
  logic       hold = 1'b0;
  logic       step;
  logic [2:0] phase;
  logic [7:0] dwellLeft;
  logic       cycleDone;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_phase_scheduler #(
    .TICK_DIV(4), .CNT_W(8), .MG_MIN(3), .MG_MAX(6),
    .Y_T(2), .AR_T(1), .SG_T(3), .PED_T(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sideCar(sideCar), .pedOn(pedOn), .hold(hold),
    .step(step), .phase(phase), .dwellLeft(dwellLeft), .cycleDone(cycleDone)
  );

  always #5 clk = ~clk;

  // Advance one posedge and sample 1ns later.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Reset released on a negedge, so the next posedge is edge 1.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    sideCar = 0; pedOn = 0; hold = 0;
    do_reset();
    #1;
    n_cmp++; if (phase !== 3'd0) begin $display("FAIL reset_phase got=%0d exp=0", phase); n_bad++; end
    n_cmp++; if (step !== 1'b0) begin $display("FAIL reset_step got=%b exp=0", step); n_bad++; end
    n_cmp++; if (dwellLeft !== 8'd6) begin $display("FAIL reset_dwellLeft got=%0d exp=6", dwellLeft); n_bad++; end
    n_cmp++; if (cycleDone !== 1'b0) begin $display("FAIL reset_cycleDone got=%b exp=0", cycleDone); n_bad++; end
    for (int e = 1; e <= 24; e++) begin
      adv();
      if (e == 12) begin
        n_cmp++; if (dwellLeft !== 8'd3) begin $display("FAIL cap_dwell12 got=%0d exp=3", dwellLeft); n_bad++; end
      end
      if (e < 24) begin
        n_cmp++; if (step !== 1'b0) begin $display("FAIL cap_nostep e=%0d got=%b exp=0", e, step); n_bad++; end
      end else begin
        n_cmp++; if (step !== 1'b1) begin $display("FAIL cap_step24 got=%b exp=1", step); n_bad++; end
        n_cmp++; if (phase !== 3'd1) begin $display("FAIL cap_phase24 got=%0d exp=1", phase); n_bad++; end
        n_cmp++; if (dwellLeft !== 8'd2) begin $display("FAIL cap_dwell24 got=%0d exp=2", dwellLeft); n_bad++; end
      end
    end
  endtask

  task automatic test_sidecar();
    int         st_edge[6] = '{12, 20, 24, 36, 44, 48};
    logic [2:0] st_ph[6]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [7:0] st_dl[6]   = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd6};
    int         idx;
    logic       exp_cd;
    sideCar = 1; pedOn = 0; hold = 0;
    do_reset();
    for (int e = 1; e <= 49; e++) begin
      adv();
      idx = -1;
      for (int k = 0; k < 6; k++) if (st_edge[k] == e) idx = k;
      exp_cd = (e == 48);
      n_cmp++; if (step !== (idx >= 0)) begin $display("FAIL sc_step e=%0d got=%b exp=%b", e, step, idx >= 0); n_bad++; end
      n_cmp++; if (cycleDone !== exp_cd) begin $display("FAIL sc_cycleDone e=%0d got=%b exp=%b", e, cycleDone, exp_cd); n_bad++; end
      if (idx >= 0) begin
        n_cmp++; if (phase !== st_ph[idx]) begin $display("FAIL sc_phase e=%0d got=%0d exp=%0d", e, phase, st_ph[idx]); n_bad++; end
        n_cmp++; if (dwellLeft !== st_dl[idx]) begin $display("FAIL sc_dwell e=%0d got=%0d exp=%0d", e, dwellLeft, st_dl[idx]); n_bad++; end
      end
    end
  endtask

  task automatic test_ped_branch();
    sideCar = 1; pedOn = 0; hold = 0;
    do_reset();
    for (int e = 1; e <= 56; e++) begin
      adv();
      if (e == 39) pedOn = 1;
      if (e == 48) begin
        n_cmp++; if (step !== 1'b1 || phase !== 3'd6) begin $display("FAIL ped_enter got step=%b phase=%0d exp step=1 phase=6", step, phase); n_bad++; end
        n_cmp++; if (cycleDone !== 1'b0) begin $display("FAIL ped_cd48 got=%b exp=0", cycleDone); n_bad++; end
        n_cmp++; if (dwellLeft !== 8'd2) begin $display("FAIL ped_dwell got=%0d exp=2", dwellLeft); n_bad++; end
      end else if (e > 48 && e < 56) begin
        n_cmp++; if (step !== 1'b0 || phase !== 3'd6) begin $display("FAIL ped_stay e=%0d got step=%b phase=%0d exp step=0 phase=6", e, step, phase); n_bad++; end
      end else if (e == 56) begin
        n_cmp++; if (step !== 1'b1 || phase !== 3'd0) begin $display("FAIL ped_exit got step=%b phase=%0d exp step=1 phase=0", step, phase); n_bad++; end
        n_cmp++; if (cycleDone !== 1'b1) begin $display("FAIL ped_cd56 got=%b exp=1", cycleDone); n_bad++; end
      end
    end
    pedOn = 0;
  endtask

  task automatic test_ped_pulse();
    logic seen_ped;
    sideCar = 1; pedOn = 0; hold = 0;
    seen_ped = 0;
    do_reset();
    for (int e = 1; e <= 48; e++) begin
      adv();
      if (e == 26) pedOn = 1;
      if (e == 30) pedOn = 0;
      if (phase === 3'd6) seen_ped = 1;
    end
    n_cmp++; if (step !== 1'b1 || phase !== 3'd0) begin $display("FAIL pulse_gr got step=%b phase=%0d exp step=1 phase=0", step, phase); n_bad++; end
    n_cmp++; if (cycleDone !== 1'b1) begin $display("FAIL pulse_cd got=%b exp=1", cycleDone); n_bad++; end
    n_cmp++; if (seen_ped !== 1'b0) begin $display("FAIL pulse_noped got=%b exp=0", seen_ped); n_bad++; end
  endtask

  task automatic test_hold();
    sideCar = 1; pedOn = 0; hold = 0;
    do_reset();
    for (int e = 1; e <= 14; e++) adv();
    n_cmp++; if (phase !== 3'd1 || dwellLeft !== 8'd2) begin $display("FAIL hold_pre got phase=%0d dl=%0d exp phase=1 dl=2", phase, dwellLeft); n_bad++; end
    hold = 1;
    for (int e = 15; e <= 24; e++) begin
      adv();
      n_cmp++; if (step !== 1'b0 || dwellLeft !== 8'd2 || phase !== 3'd1) begin
        $display("FAIL hold_frozen e=%0d got step=%b dl=%0d phase=%0d exp step=0 dl=2 phase=1", e, step, dwellLeft, phase); n_bad++;
      end
    end
    hold = 0;
    for (int e = 25; e <= 30; e++) begin
      adv();
      if (e == 26) begin
        n_cmp++; if (dwellLeft !== 8'd1) begin $display("FAIL hold_resume_dl got=%0d exp=1", dwellLeft); n_bad++; end
      end
      if (e < 30) begin
        n_cmp++; if (step !== 1'b0) begin $display("FAIL hold_nostep e=%0d got=%b exp=0", e, step); n_bad++; end
      end else begin
        n_cmp++; if (step !== 1'b1 || phase !== 3'd2) begin $display("FAIL hold_step30 got step=%b phase=%0d exp step=1 phase=2", step, phase); n_bad++; end
      end
    end
  endtask

  task automatic test_async_reset();
    sideCar = 1; pedOn = 0; hold = 0;
    do_reset();
    for (int e = 1; e <= 30; e++) adv();
    n_cmp++; if (phase !== 3'd3) begin $display("FAIL ar_pre got phase=%0d exp=3", phase); n_bad++; end
    #2;
    reset_n = 0;
    #1;
    n_cmp++; if (phase !== 3'd0 || step !== 1'b0) begin $display("FAIL ar_async got phase=%0d step=%b exp phase=0 step=0", phase, step); n_bad++; end
    n_cmp++; if (dwellLeft !== 8'd6) begin $display("FAIL ar_dwell got=%0d exp=6", dwellLeft); n_bad++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    for (int e = 1; e <= 12; e++) begin
      adv();
      if (e < 12) begin
        n_cmp++; if (step !== 1'b0) begin $display("FAIL ar_nostep e=%0d got=%b exp=0", e, step); n_bad++; end
      end else begin
        n_cmp++; if (step !== 1'b1 || phase !== 3'd1) begin $display("FAIL ar_step12 got step=%b phase=%0d exp step=1 phase=1", step, phase); n_bad++; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sidecar();
    test_ped_branch();
    test_ped_pulse();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
